// File: rtl/stat_cnt_mem_pipe_if.sv
// Bus bundle for stat_cnt_mem_pipe.
//   Update side : qStatUpdtReq, qvStatUpdtReqIndex, qvStatUpdtNum (event source -> block)
//   Read side   : qStatREn, qvStatRAddr, qStatRClr (CPU -> block)
//                 qStatRAck, qStatRDataVal, qvStatRData (block -> CPU)
//   Status      : qInitBusy (block -> CPU), high during the post-reset clear sweep
// master = event source / CPU side, slave = counter block.
interface stat_cnt_mem_pipe_if #(
    parameter int STAT_CNT  = 4096,
    parameter int INC_WIDTH = 16,
    parameter int RD_WIDTH  = 64
);
    localparam int AW = $clog2(STAT_CNT);

    logic                 qStatUpdtReq;
    logic [AW-1:0]        qvStatUpdtReqIndex;
    logic [INC_WIDTH-1:0] qvStatUpdtNum;
    logic                 qStatREn;
    logic [AW-1:0]        qvStatRAddr;
    logic                 qStatRClr;
    logic                 qStatRAck;
    logic                 qStatRDataVal;
    logic [RD_WIDTH-1:0]  qvStatRData;
    logic                 qInitBusy;

    modport master (
        output qStatUpdtReq, qvStatUpdtReqIndex, qvStatUpdtNum,
        output qStatREn, qvStatRAddr, qStatRClr,
        input  qStatRAck, qStatRDataVal, qvStatRData, qInitBusy
    );

    modport slave (
        input  qStatUpdtReq, qvStatUpdtReqIndex, qvStatUpdtNum,
        input  qStatREn, qvStatRAddr, qStatRClr,
        output qStatRAck, qStatRDataVal, qvStatRData, qInitBusy
    );
endinterface

// File: rtl/stat_cnt_mem_pipe.sv
// Statistics counter memory: STAT_CNT counters of CNT_WIDTH bits in one
// simple-dual-port RAM, updated by a 4-stage read-modify-write pipeline
// (issue / RAM data / forward+compute / RAM write) at one op per cycle.
// Ports:
//   Clock  - rising-edge clock
//   nReset - asynchronous active-low reset; restarts the clear sweep
//   bus    - stat_cnt_mem_pipe_if.slave: update requests, read handshake
//            with optional clear, read data and init-busy status
module stat_cnt_mem_pipe #(
    parameter int STAT_CNT  = 4096,
    parameter int CNT_WIDTH = 48,
    parameter int INC_WIDTH = 16,
    parameter int RD_WIDTH  = 64,
    parameter int SATURATE  = 0
) (
    input  logic               Clock,
    input  logic               nReset,
    stat_cnt_mem_pipe_if.slave bus
);
    localparam int              AW        = $clog2(STAT_CNT);
    localparam int              LAST      = STAT_CNT - 1;
    localparam logic [AW:0]     CNT_LIM   = STAT_CNT[AW:0];
    localparam logic [AW-1:0]   LAST_ADDR = LAST[AW-1:0];

    // init sweep
    logic                 busy_q, busy_d;
    logic [AW-1:0]        init_addr_q, init_addr_d;

    // issue
    logic                 upd_ok, rd_ack;

    // stage 1: RAM address registered
    logic                 s1_vld_q, s1_vld_d, s1_upd_q, s1_upd_d;
    logic                 s1_clr_q, s1_clr_d, s1_oor_q, s1_oor_d;
    logic [AW-1:0]        s1_idx_q, s1_idx_d;
    logic [INC_WIDTH-1:0] s1_num_q, s1_num_d;

    // stage 2: RAM data available, forward and compute
    logic                 s2_vld_q, s2_vld_d, s2_upd_q, s2_upd_d;
    logic                 s2_clr_q, s2_clr_d, s2_oor_q, s2_oor_d;
    logic [AW-1:0]        s2_idx_q, s2_idx_d;
    logic [INC_WIDTH-1:0] s2_num_q, s2_num_d;

    // stage 3: RAM write; stage 4: last write, kept for one more cycle
    logic                 s3_we_q, s3_we_d, s4_we_q, s4_we_d;
    logic [AW-1:0]        s3_idx_q, s3_idx_d, s4_idx_q, s4_idx_d;
    logic [CNT_WIDTH-1:0] s3_val_q, s3_val_d, s4_val_q, s4_val_d;

    // read data output
    logic                 rdv_q, rdv_d;
    logic [RD_WIDTH-1:0]  rdata_q, rdata_d;

    // RAM
    logic [CNT_WIDTH-1:0] mem [STAT_CNT];
    logic [CNT_WIDTH-1:0] ram_rd_q;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [CNT_WIDTH-1:0] wr_data;

    logic [CNT_WIDTH-1:0] old_val, upd_val;
    logic [CNT_WIDTH:0]   sum;

    always_comb begin
        upd_ok   = bus.qStatUpdtReq & ~busy_q & ({1'b0, bus.qvStatUpdtReqIndex} < CNT_LIM);
        // An update owns the slot even when it is dropped as out of range.
        rd_ack   = bus.qStatREn & ~bus.qStatUpdtReq & ~busy_q;
        s1_vld_d = upd_ok | rd_ack;
        s1_upd_d = upd_ok;
        s1_clr_d = ~upd_ok & bus.qStatRClr;
        s1_oor_d = ~upd_ok & ~({1'b0, bus.qvStatRAddr} < CNT_LIM);
        s1_idx_d = upd_ok ? bus.qvStatUpdtReqIndex : bus.qvStatRAddr;
        s1_num_d = bus.qvStatUpdtNum;
    end

    always_comb begin
        busy_d      = busy_q;
        init_addr_d = init_addr_q;
        if (busy_q) begin
            if (init_addr_q == LAST_ADDR) busy_d = 1'b0;
            else                          init_addr_d = init_addr_q + AW'(1);
        end
    end

    always_comb begin
        s2_vld_d = s1_vld_q;
        s2_upd_d = s1_upd_q;
        s2_clr_d = s1_clr_q;
        s2_oor_d = s1_oor_q;
        s2_idx_d = s1_idx_q;
        s2_num_d = s1_num_q;

        // RAM read happens one edge before the write of the op two slots
        // ahead lands, so distances 1 and 2 come from s3/s4; distance 3
        // is already in the RAM. Youngest writer wins.
        old_val = ram_rd_q;
        if (s4_we_q && s4_idx_q == s2_idx_q) old_val = s4_val_q;
        if (s3_we_q && s3_idx_q == s2_idx_q) old_val = s3_val_q;

        sum = {1'b0, old_val} + {1'b0, CNT_WIDTH'(s2_num_q)};
        if (s2_num_q == '0)                    upd_val = '0;
        else if (SATURATE != 0 && sum[CNT_WIDTH]) upd_val = '1;
        else                                   upd_val = sum[CNT_WIDTH-1:0];

        s3_we_d  = s2_vld_q & ~s2_oor_q & (s2_upd_q | s2_clr_q);
        s3_idx_d = s2_idx_q;
        s3_val_d = s2_upd_q ? upd_val : '0;

        s4_we_d  = s3_we_q;
        s4_idx_d = s3_idx_q;
        s4_val_d = s3_val_q;

        rdv_d   = s2_vld_q & ~s2_upd_q;
        rdata_d = rdata_q;
        if (rdv_d) rdata_d = s2_oor_q ? '0 : RD_WIDTH'(old_val);
    end

    always_comb begin
        wr_en   = busy_q | s3_we_q;
        wr_addr = busy_q ? init_addr_q : s3_idx_q;
        wr_data = busy_q ? '0 : s3_val_q;
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            busy_q      <= 1'b1;
            init_addr_q <= '0;
            s1_vld_q <= 1'b0; s1_upd_q <= 1'b0; s1_clr_q <= 1'b0; s1_oor_q <= 1'b0;
            s1_idx_q <= '0;   s1_num_q <= '0;
            s2_vld_q <= 1'b0; s2_upd_q <= 1'b0; s2_clr_q <= 1'b0; s2_oor_q <= 1'b0;
            s2_idx_q <= '0;   s2_num_q <= '0;
            s3_we_q  <= 1'b0; s3_idx_q <= '0;   s3_val_q <= '0;
            s4_we_q  <= 1'b0; s4_idx_q <= '0;   s4_val_q <= '0;
            rdv_q    <= 1'b0; rdata_q  <= '0;
        end else begin
            busy_q      <= busy_d;
            init_addr_q <= init_addr_d;
            s1_vld_q <= s1_vld_d; s1_upd_q <= s1_upd_d; s1_clr_q <= s1_clr_d; s1_oor_q <= s1_oor_d;
            s1_idx_q <= s1_idx_d; s1_num_q <= s1_num_d;
            s2_vld_q <= s2_vld_d; s2_upd_q <= s2_upd_d; s2_clr_q <= s2_clr_d; s2_oor_q <= s2_oor_d;
            s2_idx_q <= s2_idx_d; s2_num_q <= s2_num_d;
            s3_we_q  <= s3_we_d;  s3_idx_q <= s3_idx_d; s3_val_q <= s3_val_d;
            s4_we_q  <= s4_we_d;  s4_idx_q <= s4_idx_d; s4_val_q <= s4_val_d;
            rdv_q    <= rdv_d;    rdata_q  <= rdata_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        ram_rd_q <= mem[s1_idx_q];
    end

    assign bus.qStatRAck     = rd_ack;
    assign bus.qStatRDataVal = rdv_q;
    assign bus.qvStatRData   = rdata_q;
    assign bus.qInitBusy     = busy_q;
endmodule

// File: tb/tb_stat_cnt_mem_pipe.sv
// Bench for stat_cnt_mem_pipe: a 4096 x 48-bit instance checked every cycle
// against a sequential counter-array model, plus two 10 x 8-bit instances
// (wrap and saturate) driven in lock-step for width and range limits.
module tb_stat_cnt_mem_pipe;
    localparam int N   = 4096;
    localparam int PER = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #(PER/2) clk = ~clk;

    int errors = 0;
    int checks = 0;

    // shared stimulus, routed to the big (tgt=0) or small (tgt=1) instances
    logic        tgt   = 1'b0;
    logic        req   = 1'b0;
    logic        ren   = 1'b0;
    logic        rclr  = 1'b0;
    logic [11:0] idx   = '0;
    logic [11:0] raddr = '0;
    logic [15:0] num   = '0;

    stat_cnt_mem_pipe_if #(.STAT_CNT(N),  .INC_WIDTH(16), .RD_WIDTH(64)) sb ();
    stat_cnt_mem_pipe_if #(.STAT_CNT(10), .INC_WIDTH(8),  .RD_WIDTH(16)) sw ();
    stat_cnt_mem_pipe_if #(.STAT_CNT(10), .INC_WIDTH(8),  .RD_WIDTH(16)) ss ();

    stat_cnt_mem_pipe #(.STAT_CNT(N), .CNT_WIDTH(48), .INC_WIDTH(16), .RD_WIDTH(64), .SATURATE(0))
        u_big (.Clock(clk), .nReset(rst_n), .bus(sb.slave));
    stat_cnt_mem_pipe #(.STAT_CNT(10), .CNT_WIDTH(8), .INC_WIDTH(8), .RD_WIDTH(16), .SATURATE(0))
        u_wrap (.Clock(clk), .nReset(rst_n), .bus(sw.slave));
    stat_cnt_mem_pipe #(.STAT_CNT(10), .CNT_WIDTH(8), .INC_WIDTH(8), .RD_WIDTH(16), .SATURATE(1))
        u_sat (.Clock(clk), .nReset(rst_n), .bus(ss.slave));

    assign sb.qStatUpdtReq       = req & ~tgt;
    assign sb.qvStatUpdtReqIndex = idx;
    assign sb.qvStatUpdtNum      = num;
    assign sb.qStatREn           = ren & ~tgt;
    assign sb.qvStatRAddr        = raddr;
    assign sb.qStatRClr          = rclr;

    assign sw.qStatUpdtReq       = req & tgt;
    assign sw.qvStatUpdtReqIndex = idx[3:0];
    assign sw.qvStatUpdtNum      = num[7:0];
    assign sw.qStatREn           = ren & tgt;
    assign sw.qvStatRAddr        = raddr[3:0];
    assign sw.qStatRClr          = rclr;

    assign ss.qStatUpdtReq       = req & tgt;
    assign ss.qvStatUpdtReqIndex = idx[3:0];
    assign ss.qvStatUpdtNum      = num[7:0];
    assign ss.qStatREn           = ren & tgt;
    assign ss.qvStatRAddr        = raddr[3:0];
    assign ss.qStatRClr          = rclr;

    logic        ack_m, dv_m;
    logic [63:0] data_m;
    assign ack_m  = tgt ? sw.qStatRAck     : sb.qStatRAck;
    assign dv_m   = tgt ? sw.qStatRDataVal : sb.qStatRDataVal;
    assign data_m = tgt ? 64'(sw.qvStatRData) : sb.qvStatRData;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model of the big instance ----------------
    typedef struct { int due; logic [63:0] val; } rd_t;
    rd_t         rq[$];
    logic [47:0] mdl [N];
    int          mcyc      = 0;
    int          busy_left = N;
    logic [63:0] last_data = '0;

    always @(negedge clk) begin
        bit exp_busy, exp_ack, exp_dv;
        if (!rst_n) begin
            chk("mon_rst_busy", 64'(sb.qInitBusy), 64'd1);
            chk("mon_rst_ack",  64'(sb.qStatRAck), 64'd0);
            chk("mon_rst_dv",   64'(sb.qStatRDataVal), 64'd0);
            chk("mon_rst_data", sb.qvStatRData, 64'd0);
            foreach (mdl[i]) mdl[i] = '0;
            rq.delete();
            busy_left = N;
            last_data = '0;
        end else begin
            exp_busy = (busy_left > 0);
            exp_ack  = sb.qStatREn & ~sb.qStatUpdtReq & ~exp_busy;
            exp_dv   = (rq.size() > 0) && (rq[0].due == mcyc);
            chk("mon_busy", 64'(sb.qInitBusy), 64'(exp_busy));
            chk("mon_ack",  64'(sb.qStatRAck), 64'(exp_ack));
            chk("mon_dv",   64'(sb.qStatRDataVal), 64'(exp_dv));
            if (exp_dv) begin
                last_data = rq[0].val;
                void'(rq.pop_front());
            end
            chk("mon_data", sb.qvStatRData, last_data);
            if (!exp_busy) begin
                if (sb.qStatUpdtReq) begin
                    if (sb.qvStatUpdtNum == 16'd0) mdl[sb.qvStatUpdtReqIndex] = '0;
                    else mdl[sb.qvStatUpdtReqIndex] = mdl[sb.qvStatUpdtReqIndex] + 48'(sb.qvStatUpdtNum);
                end else if (sb.qStatREn) begin
                    rq.push_back('{due: mcyc + 3, val: 64'(mdl[sb.qvStatRAddr])});
                    if (sb.qStatRClr) mdl[sb.qvStatRAddr] = '0;
                end
            end
            if (busy_left > 0) busy_left--;
        end
        mcyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic upd_cycle(input int i, input int n);
        @(posedge clk); #1;
        req = 1'b1; ren = 1'b0; idx = 12'(i); num = 16'(n);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        req = 1'b0; ren = 1'b0; rclr = 1'b0;
    endtask

    task automatic get_dv(input time t_ack, input string name,
                          output logic [63:0] d, output logic [63:0] ds);
        int  n;
        bit  got;
        n = 0; got = 1'b0;
        while (!got && n < 16) begin
            @(negedge clk);
            n++;
            if (dv_m) got = 1'b1;
        end
        if (!got) chk({name, "_dv_timeout"}, 64'd0, 64'd1);
        else      chk({name, "_latency"}, 64'(($time - t_ack) / PER), 64'd3);
        d  = data_m;
        ds = 64'(ss.qvStatRData);
    endtask

    task automatic rd(input int a, input bit clr, input string name,
                      output logic [63:0] d, output logic [63:0] ds);
        int  n;
        time t_ack;
        @(posedge clk); #1;
        req = 1'b0; ren = 1'b1; raddr = 12'(a); rclr = clr;
        n = 0;
        @(negedge clk);
        while (!ack_m && n < 64) begin
            @(negedge clk);
            n++;
        end
        t_ack = $time;
        chk({name, "_ack"}, 64'(ack_m), 64'd1);
        @(posedge clk); #1;
        ren = 1'b0; rclr = 1'b0;
        get_dv(t_ack, name, d, ds);
    endtask

    task automatic wait_init(output int nb, output int nack, output int ndv);
        bit done;
        done = 1'b0; nb = 0; nack = 0; ndv = 0;
        while (!done && nb < 5000) begin
            @(negedge clk);
            if (dv_m) ndv++;
            if (!sb.qInitBusy) done = 1'b1;
            else begin
                nb++;
                if (sb.qStatRAck) nack++;
                @(posedge clk); #1;
                if (nb >= 20) req = 1'b0;
            end
        end
        if (!done) chk("init_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #(PER * 60000);
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    logic [63:0] d, ds;
    int          nb, nack, ndv, n_ack, n_dv_rst;
    time         t_ack;
    int          ti [6] = '{20, 21, 20, 22, 21, 20};
    int          tn [6] = '{1, 2, 4, 8, 16, 32};

    initial begin
        // reset and init sweep; an update and a read are held during the sweep
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(sb.qInitBusy), 64'd1);
        chk("rst_ack",  64'(sb.qStatRAck), 64'd0);
        chk("rst_dv",   64'(sb.qStatRDataVal), 64'd0);
        chk("rst_data", sb.qvStatRData, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        req = 1'b1; idx = 12'd5; num = 16'd9;
        ren = 1'b1; raddr = 12'd5; rclr = 1'b0;
        wait_init(nb, nack, ndv);
        chk("init_busy_cycles", 64'(nb), 64'd4096);
        chk("init_no_ack_in_sweep", 64'(nack), 64'd0);
        chk("init_first_ack", 64'(ack_m), 64'd1);
        t_ack = $time;
        @(posedge clk); #1;
        ren = 1'b0;
        get_dv(t_ack, "init_rd5", d, ds);
        chk("init_rd5_data", d, 64'd0);

        // back-to-back same index
        repeat (100) upd_cycle(7, 1);
        rd(7, 1'b0, "b2b7", d, ds);
        chk("b2b7_data", d, 64'd100);

        // interleaved indices, forwarding at distances 1..3
        foreach (ti[k]) upd_cycle(ti[k], tn[k]);
        rd(20, 1'b0, "mix20", d, ds); chk("mix20_data", d, 64'd37);
        rd(21, 1'b0, "mix21", d, ds); chk("mix21_data", d, 64'd18);
        rd(22, 1'b0, "mix22", d, ds); chk("mix22_data", d, 64'd8);

        // consecutive reads acknowledged in consecutive cycles
        @(posedge clk); #1; req = 1'b0; ren = 1'b1; raddr = 12'd20;
        @(posedge clk); #1; raddr = 12'd21;
        @(posedge clk); #1; raddr = 12'd22;
        @(posedge clk); #1; ren = 1'b0;
        repeat (5) @(negedge clk);

        // read arbitration against continuous updates to the same index
        @(posedge clk); #1;
        ren = 1'b1; raddr = 12'd3; rclr = 1'b0;
        req = 1'b1; idx = 12'd3; num = 16'd1;
        n_ack = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack_m) n_ack++;
            @(posedge clk); #1;
            if (i == 9) req = 1'b0;
        end
        chk("arb_no_ack_while_updating", 64'(n_ack), 64'd0);
        @(negedge clk);
        chk("arb_ack_first_idle", 64'(ack_m), 64'd1);
        t_ack = $time;
        @(posedge clk); #1;
        ren = 1'b0;
        get_dv(t_ack, "arb3", d, ds);
        chk("arb3_data", d, 64'd10);

        // read-and-clear followed by an update in the next cycle
        upd_cycle(9, 50);
        @(posedge clk); #1;
        req = 1'b0; ren = 1'b1; raddr = 12'd9; rclr = 1'b1;
        @(negedge clk);
        chk("rclr_ack", 64'(ack_m), 64'd1);
        t_ack = $time;
        @(posedge clk); #1;
        ren = 1'b0; rclr = 1'b0; req = 1'b1; idx = 12'd9; num = 16'd2;
        @(posedge clk); #1;
        req = 1'b0;
        get_dv(t_ack, "rclr9", d, ds);
        chk("rclr9_data", d, 64'd50);
        rd(9, 1'b0, "after_clr9", d, ds);
        chk("after_clr9_data", d, 64'd2);

        // width limits and out-of-range on the 10 x 8-bit instances
        idle();
        @(posedge clk); #1; tgt = 1'b1;
        upd_cycle(4, 200);
        upd_cycle(4, 100);
        rd(4, 1'b0, "w4", d, ds);
        chk("w4_wrap", d, 64'd44);
        chk("w4_sat", ds, 64'd255);
        upd_cycle(4, 0);
        rd(4, 1'b0, "w4z", d, ds);
        chk("w4z_wrap", d, 64'd0);
        chk("w4z_sat", ds, 64'd0);
        upd_cycle(5, 10);
        upd_cycle(5, 20);
        rd(5, 1'b0, "w5", d, ds);
        chk("w5_wrap", d, 64'd30);
        chk("w5_sat", ds, 64'd30);
        upd_cycle(12, 5);
        rd(12, 1'b1, "oor12", d, ds);
        chk("oor12_data", d, 64'd0);
        rd(2, 1'b0, "oor_alias2", d, ds);
        chk("oor_alias2_data", d, 64'd0);
        rd(9, 1'b0, "last9", d, ds);
        chk("last9_data", d, 64'd0);

        // reset in the middle of in-flight operations
        idle();
        @(posedge clk); #1; tgt = 1'b0;
        upd_cycle(2, 5);
        @(posedge clk); #1;
        req = 1'b0; ren = 1'b1; raddr = 12'd2;
        @(negedge clk);
        chk("midrst_ack", 64'(ack_m), 64'd1);
        @(posedge clk); #1;
        ren = 1'b0; rst_n = 1'b0;
        n_dv_rst = 0;
        repeat (3) begin
            @(negedge clk);
            if (dv_m) n_dv_rst++;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_init(nb, nack, ndv);
        chk("midrst_busy_cycles", 64'(nb), 64'd4096);
        chk("midrst_no_dv", 64'(n_dv_rst + ndv), 64'd0);
        rd(2, 1'b0, "midrst2", d, ds);
        chk("midrst2_data", d, 64'd0);

        idle();
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
